// File: rtl/npu_mac_accum.sv
// Signed fixed-point multiply-accumulate engine: one dot product per mac_start, saturated result.
// Define NPU_MAC_ROUND_EN for round-half-up before the fractional shift; default is floor.
module npu_mac_accum #(
  parameter int DATA_WIDTH    = 16,
  parameter int NUM_FRAC_BITS = 10,
  parameter int ACC_WIDTH     = 40
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [2:0]                   npu_layer_in_progress,
  input  logic                         mac_start,
  input  logic [8:0]                   mac_len,
  input  logic                         act_valid,
  input  logic signed [DATA_WIDTH-1:0] act_data,
  input  logic signed [DATA_WIDTH-1:0] wgt_data,
  output logic                         act_ready,
  output logic                         mac_busy,
  output logic                         mac_valid,
  output logic signed [DATA_WIDTH-1:0] mac_out,
  output logic                         mac_ovf
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, OUT} state_t;

  state_t                 state;
  logic [8:0]             remaining;
  logic signed [PW-1:0]   prod;
  logic                   prod_vld;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                   beat;
  logic signed [RW-1:0]   acc_ext;
  logic signed [RW-1:0]   rounded;
  logic signed [RW-1:0]   shifted;
  logic                   sat_hi;
  logic                   sat_lo;
  logic signed [DATA_WIDTH-1:0] result;

  assign act_ready = (state == ACCUM) && (remaining != 9'd0);
  assign beat      = act_ready && act_valid;

  // One guard bit keeps the rounding increment from ever wrapping the accumulator.
  always_comb begin
    acc_ext = {acc[ACC_WIDTH-1], acc};
`ifdef NPU_MAC_ROUND_EN
    rounded = acc_ext + (RW'(1) << (NUM_FRAC_BITS - 1));
`else
    rounded = acc_ext;
`endif
    shifted = rounded >>> NUM_FRAC_BITS;
    sat_hi  = shifted > SAT_MAX;
    sat_lo  = shifted < SAT_MIN;
    if (sat_hi)      result = SAT_MAX[DATA_WIDTH-1:0];
    else if (sat_lo) result = SAT_MIN[DATA_WIDTH-1:0];
    else             result = shifted[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      remaining <= '0;
      prod      <= '0;
      prod_vld  <= 1'b0;
      acc       <= '0;
      mac_busy  <= 1'b0;
      mac_valid <= 1'b0;
      mac_ovf   <= 1'b0;
      mac_out   <= '0;
    end else begin
      mac_valid <= 1'b0;
      mac_ovf   <= 1'b0;
      if (npu_layer_in_progress == 3'd0) begin
        // Layer abort: drop everything in flight but keep the last published result.
        state     <= IDLE;
        remaining <= '0;
        prod      <= '0;
        prod_vld  <= 1'b0;
        acc       <= '0;
        mac_busy  <= 1'b0;
      end else begin
        prod_vld <= beat;
        if (beat)
          prod <= PW'(act_data) * PW'(wgt_data);
        if (prod_vld)
          acc <= acc + {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
        case (state)
          IDLE: begin
            mac_busy <= 1'b0;
            if (mac_start) begin
              remaining <= mac_len;
              acc       <= '0;
              prod_vld  <= 1'b0;
              mac_busy  <= 1'b1;
              state     <= (mac_len != 9'd0) ? ACCUM : OUT;
            end
          end
          ACCUM: begin
            if (beat) begin
              remaining <= remaining - 9'd1;
              if (remaining == 9'd1)
                state <= DRAIN;
            end
          end
          DRAIN: begin
            if (!prod_vld)
              state <= OUT;
          end
          OUT: begin
            mac_out   <= result;
            mac_ovf   <= sat_hi || sat_lo;
            mac_valid <= 1'b1;
            state     <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_mac_accum.sv
// Randomised self-checking bench for npu_mac_accum against a dot-product reference model.
// Honours NPU_MAC_ROUND_EN the same way the design does.
module tb_npu_mac_accum;

  logic               clk;
  logic               rst;
  logic [2:0]         npu_layer_in_progress;
  logic               mac_start;
  logic [8:0]         mac_len;
  logic               act_valid;
  logic signed [15:0] act_data;
  logic signed [15:0] wgt_data;
  logic               act_ready;
  logic               mac_busy;
  logic               mac_valid;
  logic signed [15:0] mac_out;
  logic               mac_ovf;

  npu_mac_accum dut (
    .clk(clk), .rst(rst), .npu_layer_in_progress(npu_layer_in_progress),
    .mac_start(mac_start), .mac_len(mac_len), .act_valid(act_valid),
    .act_data(act_data), .wgt_data(wgt_data), .act_ready(act_ready),
    .mac_busy(mac_busy), .mac_valid(mac_valid), .mac_out(mac_out), .mac_ovf(mac_ovf)
  );

  int     checks = 0;
  int     failures = 0;
  int     edge_count = 0;
  bit     check_en = 0;
  bit     pend_valid = 0;
  int     valid_edge = 0;
  longint exp_out = 0;
  bit     exp_ovf = 0;
  longint last_out = 0;
  bit     model_ready = 0;
  bit     busy_on = 0;
  int     busy_from = 0;
  int     busy_to = 0;
  bit     use_lit = 0;
  longint lit_out = 0;
  bit     lit_ovf = 0;
  int     act_q[$];
  int     wgt_q[$];
  bit     gap_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_count <= edge_count + 1;

  task automatic check_output(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edge_count);
    end
  endtask

  function automatic longint floor_div(input longint s);
    longint q;
    q = s / 1024;
    if (s < 0 && q * 1024 != s) q = q - 1;
    return q;
  endfunction

  // Every cycle: the valid pulse lands exactly where the model says, the output is held otherwise.
  always @(negedge clk) begin
    logic exp_v;
    logic exp_busy;
    if (rst && check_en) begin
      exp_v    = pend_valid && (edge_count == valid_edge);
      exp_busy = busy_on && (edge_count >= busy_from) && (edge_count <= busy_to);
      check_output("mac_valid", longint'(mac_valid), longint'(exp_v));
      if (exp_v) begin
        check_output("mac_out", longint'(mac_out), exp_out);
        check_output("mac_ovf", longint'(mac_ovf), longint'(exp_ovf));
        if (use_lit) begin
          check_output("mac_out_literal", longint'(mac_out), lit_out);
          check_output("mac_ovf_literal", longint'(mac_ovf), longint'(lit_ovf));
        end
        last_out   = exp_out;
        pend_valid = 0;
      end else begin
        check_output("mac_out_hold", longint'(mac_out), last_out);
      end
      check_output("act_ready", longint'(act_ready), longint'(model_ready));
      check_output("mac_busy", longint'(mac_busy), longint'(exp_busy));
    end
  end

  // Runs one dot product from act_q/wgt_q; gap_q (if filled) dictates act_valid per cycle.
  task automatic apply_stimulus(input int len, input bit gaps_random, input bit start_in_accum,
                                input bit start_in_out, input int abort_at, input bit reset_drain);
    int     accepted = 0;
    int     gidx = 0;
    int     guard = 0;
    bit     v;
    bit     side_start_done = 0;
    longint sum = 0;
    longint q;
    mac_start = 1'b1;
    mac_len   = 9'(len);
    act_valid = 1'b0;
    @(posedge clk); #1;
    mac_start   = 1'b0;
    busy_on     = 1;
    busy_from   = edge_count;
    busy_to     = 1 << 30;
    model_ready = (len != 0);
    while (accepted < len) begin
      guard++;
      if (guard > 5000) begin
        check_output("beat_loop_timeout", longint'(accepted), longint'(len));
        break;
      end
      if (gidx < gap_q.size()) begin
        v = gap_q[gidx];
        gidx++;
      end else begin
        v = gaps_random ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (abort_at >= 0 && accepted == abort_at) begin
        npu_layer_in_progress = 3'd0;
        act_valid = 1'b1;
        act_data  = 16'(act_q[accepted]);
        wgt_data  = 16'(wgt_q[accepted]);
        @(posedge clk); #1;
        npu_layer_in_progress = 3'(1 + $urandom_range(0, 6));
        act_valid   = 1'b0;
        busy_on     = 0;
        model_ready = 0;
        return;
      end
      if (start_in_accum && !side_start_done && accepted == len / 2) begin
        mac_start = 1'b1;
        mac_len   = 9'($urandom_range(0, 511));
        side_start_done = 1;
      end
      act_valid = v;
      if (v) begin
        act_data = 16'(act_q[accepted]);
        wgt_data = 16'(wgt_q[accepted]);
      end else begin
        act_data = 16'($urandom_range(0, 65535));
        wgt_data = 16'($urandom_range(0, 65535));
      end
      @(posedge clk); #1;
      mac_start = 1'b0;
      if (v) begin
        sum += longint'(act_q[accepted]) * longint'(wgt_q[accepted]);
        accepted++;
      end
    end
    act_valid   = 1'b0;
    model_ready = 0;
    valid_edge  = (len == 0) ? edge_count + 1 : edge_count + 3;
    if (reset_drain) begin
      rst        = 1'b0;
      pend_valid = 0;
      busy_on    = 0;
      last_out   = 0;
      @(negedge clk); #2;
      rst = 1'b1;
      @(posedge clk); #1;
      return;
    end
`ifdef NPU_MAC_ROUND_EN
    q = floor_div(sum + 512);
`else
    q = floor_div(sum);
`endif
    if (q > 32767) begin
      exp_out = 32767;
      exp_ovf = 1;
    end else if (q < -32768) begin
      exp_out = -32768;
      exp_ovf = 1;
    end else begin
      exp_out = q;
      exp_ovf = 0;
    end
    busy_to    = valid_edge;
    pend_valid = 1;
    if (start_in_out) begin
      while (edge_count < valid_edge - 1) begin
        @(posedge clk); #1;
      end
      mac_start = 1'b1;
      mac_len   = 9'd7;
      @(posedge clk); #1;
      mac_start = 1'b0;
    end
    while (edge_count < valid_edge) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
  endtask

  task automatic fill_const(input int len, input int a, input int w);
    act_q.delete(); wgt_q.delete(); gap_q.delete();
    for (int i = 0; i < len; i++) begin
      act_q.push_back(a);
      wgt_q.push_back(w);
    end
  endtask

  task automatic run_literal(input int len, input int a, input int w, input longint lo, input bit lv);
    fill_const(len, a, w);
    use_lit = 1; lit_out = lo; lit_ovf = lv;
    apply_stimulus(len, 1, 0, 0, -1, 0);
    use_lit = 0;
  endtask

  initial begin
    int  len;
    bit  big;
    rst = 1'b0;
    npu_layer_in_progress = 3'd1;
    mac_start = 1'b0; mac_len = '0; act_valid = 1'b0; act_data = '0; wgt_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_act_ready", longint'(act_ready), 0);
    check_output("reset_mac_busy", longint'(mac_busy), 0);
    check_output("reset_mac_valid", longint'(mac_valid), 0);
    check_output("reset_mac_ovf", longint'(mac_ovf), 0);
    check_output("reset_mac_out", longint'(mac_out), 0);
    @(negedge clk); #2;
    rst = 1'b1;
    check_en = 1;

    // Start on the very first edge after reset release.
    run_literal(4, 1024, 1024, 4096, 0);
    run_literal(200, 32767, 32767, 32767, 1);
    run_literal(200, -32768, 32767, -32768, 1);
    run_literal(511, -32768, -32768, 32767, 1);
`ifdef NPU_MAC_ROUND_EN
    run_literal(1, 1, 512, 1, 0);
    run_literal(1, -1, 512, 0, 0);
`else
    run_literal(1, 1, 512, 0, 0);
    run_literal(1, -1, 512, -1, 0);
`endif

    // Zero-length product, with a start request landing in its OUT cycle.
    fill_const(0, 0, 0);
    use_lit = 1; lit_out = 0; lit_ovf = 0;
    apply_stimulus(0, 1, 0, 1, -1, 0);
    use_lit = 0;

    fill_const(6, 300, -200);
    apply_stimulus(6, 1, 1, 0, -1, 0);

    // Sparse act_valid pattern must consume exactly three beats.
    act_q = '{1024, 2048, -1024};
    wgt_q = '{1024, 1024, 1024};
    gap_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    use_lit = 1; lit_out = 2048; lit_ovf = 0;
    apply_stimulus(3, 0, 0, 0, -1, 0);
    use_lit = 0;

    fill_const(10, 1000, 1000);
    apply_stimulus(10, 1, 0, 0, 4, 0);
    run_literal(1, 2048, 3072, 6144, 0);

    fill_const(5, 500, 700);
    apply_stimulus(5, 1, 0, 0, -1, 1);
    run_literal(1, -2048, 1024, -2048, 0);

    for (int r = 0; r < 30; r++) begin
      len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 48));
      big = ($urandom_range(0, 3) == 0);
      act_q.delete(); wgt_q.delete(); gap_q.delete();
      for (int i = 0; i < len; i++) begin
        if (big) begin
          act_q.push_back(int'($urandom_range(0, 65535)) - 32768);
          wgt_q.push_back(int'($urandom_range(0, 65535)) - 32768);
        end else begin
          act_q.push_back(int'($urandom_range(0, 1023)) - 512);
          wgt_q.push_back(int'($urandom_range(0, 1023)) - 512);
        end
      end
      apply_stimulus(len, 1, (len >= 2) && ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 3) == 0), -1, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    check_output("final_no_pending", longint'(pend_valid), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/npu_mac_accum.md
NPU_MAC_ACCUM -- requirements
Module: npu_mac_accum

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of activation, weight and result words.
REQ-002 Parameter NUM_FRAC_BITS, default 10: fractional bits of all fixed-point operands and of the result.
REQ-003 Parameter ACC_WIDTH, default 40: accumulator width; SHALL be at least 2*DATA_WIDTH+8.
REQ-004 clk  input  1  clock; all state changes on the rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-low.
REQ-006 npu_layer_in_progress  input  3  current layer encoding; 0 means idle/abort.
REQ-007 mac_start  input  1  single-cycle request to begin one dot product.
REQ-008 mac_len  input  9  number of product terms, 0..511; sampled with mac_start.
REQ-009 act_valid  input  1  act_data/wgt_data pair is valid.
REQ-010 act_data  input  DATA_WIDTH  signed activation operand.
REQ-011 wgt_data  input  DATA_WIDTH  signed weight operand.
REQ-012 act_ready  output  1  block accepts a pair; a beat transfers on an edge where act_valid and act_ready are both 1.
REQ-013 mac_busy  output  1  high from the accepted mac_start until the mac_valid pulse, inclusive.
REQ-014 mac_valid  output  1  single-cycle pulse: mac_out holds a new result.
REQ-015 mac_out  output  DATA_WIDTH  signed saturated result; held until the next mac_valid.
REQ-016 mac_ovf  output  1  pulses with mac_valid when that result was saturated.

Function
REQ-017 FSM states SHALL be IDLE, ACCUM, DRAIN and OUT.
REQ-018 IDLE: when mac_start=1 and npu_layer_in_progress!=0, latch mac_len, clear accumulator; go to ACCUM if mac_len!=0, else OUT.
REQ-019 mac_start outside IDLE SHALL be ignored.
REQ-020 act_ready SHALL be 1 only in ACCUM with remaining-beat count >0.
REQ-021 Each accepted beat: product = act_data*wgt_data (full 2*DATA_WIDTH signed), registered one cycle, then sign-extended and added to the accumulator the next cycle.
REQ-022 Gaps in act_valid SHALL stall without loss or duplication of beats.
REQ-023 After the last beat is accepted: ACCUM->DRAIN; DRAIN lasts until the pipeline is empty, then OUT.
REQ-024 Latency: last beat accepted on edge N -> mac_valid high in the cycle after edge N+3; mac_len=0 accepted on edge N -> mac_valid after edge N+1 with mac_out=0.
REQ-025 Result = accumulator arithmetically shifted right by NUM_FRAC_BITS (rounding per REQ-033/034), then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
REQ-026 mac_ovf=1 with mac_valid iff saturation changed the value.
REQ-027 OUT lasts exactly one cycle, then IDLE; mac_start in that OUT cycle is ignored; a new mac_start in the following cycle is accepted.
REQ-028 npu_layer_in_progress==0 in any state: next edge -> IDLE, pipeline and accumulator cleared, no mac_valid, mac_out held.
REQ-029 Accumulator SHALL never wrap for mac_len<=511 at full-scale operands.

Reset
REQ-030 On rst=0: state IDLE; act_ready=0, mac_busy=0, mac_valid=0, mac_ovf=0, mac_out=0; accumulator, product register and beat counter cleared.
REQ-031 Reset asserted mid-operation SHALL discard the operation with no mac_valid.
REQ-032 First legal mac_start is the first edge after rst deasserts.

Configuration
REQ-033 Macro NPU_MAC_ROUND_EN defined: add 2^(NUM_FRAC_BITS-1) to the accumulator before the shift (round half up).
REQ-034 Macro NPU_MAC_ROUND_EN undefined: plain arithmetic shift (floor); latency and all other behaviour identical.

Verification
REQ-035 mac_len=4, four beats act=1024, wgt=1024 -> one mac_valid, mac_out=4096, mac_ovf=0, 3 cycles after last beat.
REQ-036 mac_len=200, beats 32767*32767 -> mac_out=32767, mac_ovf=1; beats -32768*32767 -> mac_out=-32768, mac_ovf=1.
REQ-037 mac_len=1, act=1, wgt=512 -> mac_out=1 with NPU_MAC_ROUND_EN, 0 without; act=-1, wgt=512 -> 0 with, -1 without.
REQ-038 mac_len=0 -> mac_valid one cycle after start, mac_out=0; mac_start pulsed during ACCUM -> ignored, single result.
REQ-039 mac_len=3 with act_valid 1,0,0,1,0,1 (values 1024,2048,-1024, wgt 1024) -> mac_out=2048, no extra beats consumed.
REQ-040 npu_layer_in_progress forced to 0 mid-ACCUM, and separately rst pulsed mid-DRAIN -> no mac_valid, IDLE next edge, subsequent mac_len=1 run correct.
